// File: rtl/ring_decoder_if.sv
// Bundles the signals between a ring counter (or its driver) and
// ring_decoder. clk and reset stay outside the interface as plain ports.
//   master : drives the sample stream and reads back the decoder results
//   slave  : the decoder itself
interface ring_decoder_if #(
    parameter int N  = 4,
    parameter int IW = 2,
    parameter int CW = 8
);
    logic          clear;        // synchronous resync
    logic          in_valid;     // ring_in sampled on this edge
    logic          ring_load;    // sample follows a parallel load
    logic [N-1:0]  ring_in;      // one-hot counter state
    logic [IW-1:0] index_out;    // binary position of the hot bit
    logic          index_valid;  // pulse: index_out updated
    logic          onehot_err;   // pulse: sample not one-hot
    logic          seq_err;      // pulse: sample not the expected next index
    logic          locked;       // tracking the sequence
    logic [CW-1:0] wrap_count;   // legal 0 -> N-1 transitions, saturating

    modport master (
        output clear, in_valid, ring_load, ring_in,
        input  index_out, index_valid, onehot_err, seq_err, locked, wrap_count
    );
    modport slave (
        input  clear, in_valid, ring_load, ring_in,
        output index_out, index_valid, onehot_err, seq_err, locked, wrap_count
    );
endinterface

// File: rtl/ring_decoder.sv
// Monitor/decoder for a rotate-right one-hot ring counter.
// On each in_valid sample it decodes the hot-bit position, flags non-one-hot
// words, checks the rotation order (i -> i-1 mod N) and counts full
// revolutions (0 -> N-1 transitions). All outputs are registered.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-high reset
//   bus    : ring_decoder_if.slave (clear/in_valid/ring_load/ring_in in,
//            index_out/index_valid/onehot_err/seq_err/locked/wrap_count out)
module ring_decoder #(
    parameter int N  = 4,
    parameter int IW = 2,
    parameter int CW = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    ring_decoder_if.slave        bus
);

    typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

    state_t        r_state, w_state_nxt;
    logic [IW-1:0] r_index, w_index_nxt;
    logic [IW-1:0] r_expected, w_expected_nxt;
    logic [CW-1:0] r_wrap, w_wrap_nxt;
    logic          r_ivalid, w_ivalid_nxt;
    logic          r_oh_err, w_oh_err_nxt;
    logic          r_seq_err, w_seq_err_nxt;

    logic [IW-1:0] w_idx;
    logic [IW-1:0] w_idx_dec;
    logic          w_onehot;
    int            w_ones;

    // Decode position and count set bits in one pass.
    always_comb begin
        w_idx  = '0;
        w_ones = 0;
        for (int i = 0; i < N; i++) begin
            if (bus.ring_in[i]) begin
                w_idx  = IW'(i);
                w_ones = w_ones + 1;
            end
        end
        w_onehot = (w_ones == 1);
    end

    // Modulo-N decrement; wraps 0 to N-1 even when N is not a power of two.
    assign w_idx_dec = (w_idx == '0) ? IW'(N - 1) : w_idx - 1'b1;

    always_comb begin
        w_state_nxt    = r_state;
        w_index_nxt    = r_index;
        w_expected_nxt = r_expected;
        w_wrap_nxt     = r_wrap;
        w_ivalid_nxt   = 1'b0;
        w_oh_err_nxt   = 1'b0;
        w_seq_err_nxt  = 1'b0;

        if (bus.clear) begin
            w_state_nxt    = UNLOCKED;
            w_wrap_nxt     = '0;
            w_expected_nxt = '0;
        end else if (bus.in_valid) begin
            if (!w_onehot) begin
                w_oh_err_nxt = 1'b1;
                w_state_nxt  = UNLOCKED;
            end else begin
                w_index_nxt    = w_idx;
                w_ivalid_nxt   = 1'b1;
                w_expected_nxt = w_idx_dec;
                w_state_nxt    = LOCKED;
                // Unlocked and load samples only (re)establish the expectation.
                if (r_state == LOCKED && !bus.ring_load) begin
                    if (w_idx != r_expected) begin
                        w_seq_err_nxt = 1'b1;
                    end else if (r_index == '0 && w_idx == IW'(N - 1) &&
                                 r_wrap != '1) begin
                        w_wrap_nxt = r_wrap + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= UNLOCKED;
            r_index    <= '0;
            r_expected <= '0;
            r_wrap     <= '0;
            r_ivalid   <= 1'b0;
            r_oh_err   <= 1'b0;
            r_seq_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_index    <= w_index_nxt;
            r_expected <= w_expected_nxt;
            r_wrap     <= w_wrap_nxt;
            r_ivalid   <= w_ivalid_nxt;
            r_oh_err   <= w_oh_err_nxt;
            r_seq_err  <= w_seq_err_nxt;
        end
    end

    assign bus.index_out   = r_index;
    assign bus.index_valid = r_ivalid;
    assign bus.onehot_err  = r_oh_err;
    assign bus.seq_err     = r_seq_err;
    assign bus.locked      = (r_state == LOCKED);
    assign bus.wrap_count  = r_wrap;

endmodule
